transmisor_ps2: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set LEDs, 0xF4 enable) to a keyboard over the open-drain ps2c/ps2d lines.
- Inhibits the bus with a request-to-send (RTS) low pulse, then shifts out the frame on device-generated clock edges: start, 8 data LSB first, odd parity, stop.
- Then waits for the device ACK clock.
- Sits beside the PS/2 receiver in the keyboard interface; its `tx_idle` gates the receiver's `rx_en` so the two never use the bus at once.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/transmisor_ps2_if.sv | 11 +
 rtl/ps2_filtro_flanco.sv | 34 +++
 rtl/transmisor_ps2.sv | 112 +++++++++++
 tb/tb_transmisor_ps2.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, default timing constants, parity helper.
// Used by both the transmitter and the receiver.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RTS   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RTS   = ST_RTS,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_DONE  = ST_DONE
  } ps2_state_e;

  localparam int FILTER_LEN_DEF = 8;
  // 100 us request-to-send at a 50 MHz system clock
  localparam int RTS_CYCLES_DEF = 5000;

  // Odd parity: {odd_par(d), d} always carries an odd number of ones.
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/transmisor_ps2_if.sv
// Host-side command/status bundle of the PS/2 transmitter.
interface transmisor_ps2_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  modport master (output wr_ps2, din, input tx_idle, tx_done_tick, ack_err);
  modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, ack_err);
endinterface

// File: rtl/ps2_filtro_flanco.sv
// ps2c glitch filter with falling-edge detector; the filtered clock only moves
// when FILTER_LEN consecutive samples agree.
module ps2_filtro_flanco #(
  parameter int FILTER_LEN = ps2_pkg::FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic f_ps2c,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] filter_reg;
  logic                  f_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_reg <= '0;
      f_ps2c     <= 1'b0;
    end else begin
      filter_reg <= {ps2c_in, filter_reg[FILTER_LEN-1:1]};
      f_ps2c     <= f_next;
    end
  end

  always_comb begin
    f_next = f_ps2c;
    if (&filter_reg)       f_next = 1'b1;
    else if (~|filter_reg) f_next = 1'b0;
  end

  assign fall_edge = f_ps2c & ~f_next;

endmodule

// File: rtl/transmisor_ps2.sv
// Host-to-device PS/2 transmitter: RTS pulse, then start/8 data/odd parity/stop
// on device clock falls, then waits for the device ACK edge.
// Optional TX_ACK_CHECK_EN: latch the ACK sample into a sticky ack_err.
module transmisor_ps2
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES = RTS_CYCLES_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  transmisor_ps2_if.slave     bus,
  input  logic                ps2c_in,
  input  logic                ps2d_in,
  output logic                ps2c_oe,
  output logic                ps2d_oe
);

  localparam int            CW       = $clog2(RTS_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(RTS_CYCLES - 1);

  ps2_state_e    state_reg, state_next;
  logic [8:0]    b_reg, b_next;
  logic [3:0]    n_reg, n_next;
  logic [CW-1:0] c_reg, c_next;
  logic          fall_edge;

  ps2_filtro_flanco #(.FILTER_LEN(FILTER_LEN)) u_filtro (
    .clk       (clk),
    .reset     (reset),
    .ps2c_in   (ps2c_in),
    .f_ps2c    (),
    .fall_edge (fall_edge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      b_reg     <= '0;
      n_reg     <= '0;
      c_reg     <= '0;
    end else begin
      state_reg <= state_next;
      b_reg     <= b_next;
      n_reg     <= n_next;
      c_reg     <= c_next;
    end
  end

  // Falls during RTS are our own clock pull-down, so rts never looks at fall_edge.
  always_comb begin
    state_next = state_reg;
    b_next     = b_reg;
    n_next     = n_reg;
    c_next     = c_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (bus.wr_ps2) begin
          b_next     = {odd_par(bus.din), bus.din};
          c_next     = '0;
          state_next = S_RTS;
        end
      end
      S_RTS: begin
        c_next = c_reg + 1'b1;
        if (c_reg == CNT_LAST) state_next = S_START;
      end
      S_START: begin
        if (fall_edge) begin
          n_next     = 4'd8;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (fall_edge) begin
          if (n_reg == 4'd0) begin
            state_next = S_STOP;
          end else begin
            b_next = {1'b0, b_reg[8:1]};
            n_next = n_reg - 1'b1;
          end
        end
      end
      S_STOP: begin
        if (fall_edge) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign ps2c_oe          = (state_reg == S_RTS);
  assign ps2d_oe          = (state_reg == S_START) | ((state_reg == S_DATA) & ~b_reg[0]);
  assign bus.tx_idle      = (state_reg == S_IDLE);
  assign bus.tx_done_tick = (state_reg == S_DONE);

`ifdef TX_ACK_CHECK_EN
  logic ack_reg;

  // Device ACK pulls ps2d low around edge 11; a high sample means no ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    ack_reg <= 1'b0;
    else if (state_reg == S_IDLE && bus.wr_ps2)    ack_reg <= 1'b0;
    else if (state_reg == S_STOP && fall_edge)     ack_reg <= ps2d_in;
  end

  assign bus.ack_err = ack_reg;
`else
  assign bus.ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_transmisor_ps2.sv
// Bench for transmisor_ps2: device-side PS/2 model drives the clock, captures
// the frame and ACKs; captured frames are compared with a reference frame.
module tb_transmisor_ps2;
  localparam int RTS  = 20;
  localparam int FL   = 8;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dev_c = 1'b0;
  logic dev_d = 1'b0;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;

  int vectors = 0;
  int errors  = 0;

  transmisor_ps2_if bus();

  transmisor_ps2 #(.RTS_CYCLES(RTS), .FILTER_LEN(FL)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe)
  );

  always #5 clk = ~clk;

  // Open-drain bus with pull-ups
  assign ps2c_in = ~(ps2c_oe | dev_c);
  assign ps2d_in = ~(ps2d_oe | dev_d);

  int   tick_cnt    = 0;
  int   idle_ok_cnt = 0;
  logic ack_at_tick = 1'b0;
  logic prev_tick   = 1'b0;

  always @(negedge clk) begin
    if (prev_tick && bus.tx_idle) idle_ok_cnt <= idle_ok_cnt + 1;
    if (bus.tx_done_tick) begin
      tick_cnt    <= tick_cnt + 1;
      ack_at_tick <= bus.ack_err;
    end
    prev_tick <= bus.tx_done_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame in line order: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic exp_ack_err(input bit acked);
`ifdef TX_ACK_CHECK_EN
    return !acked;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send(input logic [7:0] d, input bit ack, input bit glitch,
                      input bit busy, input string tag);
    logic [10:0] cap;
    int cnt, t0, i0;
    t0 = tick_cnt;
    i0 = idle_ok_cnt;
    @(negedge clk);
    bus.wr_ps2 = 1'b1;
    bus.din    = d;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'($urandom);
    chk({tag, " ack_clr"}, 32'(bus.ack_err), 32'd0);
    cnt = 0;
    while (ps2c_oe === 1'b1 && cnt < RTS + 5) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " rts_len"}, 32'(cnt), 32'(RTS));
    chk({tag, " start_oe"}, 32'(ps2d_oe), 32'd1);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      cap[k] = ps2d_in;
      dev_d  = (k == 10) && ack;
      dev_c  = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        if (glitch && k >= 2 && k <= 8 && c == 10) dev_c = 1'b1;
        if (glitch && k >= 2 && k <= 8 && c == 13) dev_c = 1'b0;
        if (busy && k == 5 && c == 5) begin
          bus.wr_ps2 = 1'b1;
          bus.din    = 8'h55;
        end
        if (busy && k == 5 && c == 6) bus.wr_ps2 = 1'b0;
        @(negedge clk);
      end
      dev_d = 1'b0;
    end
    chk({tag, " frame"}, 32'(cap), 32'(ref_frame(d)));
    chk({tag, " ticks"}, 32'(tick_cnt - t0), 32'd1);
    chk({tag, " idle_after_tick"}, 32'(idle_ok_cnt - i0), 32'd1);
    chk({tag, " ack_at_tick"}, 32'(ack_at_tick), 32'(exp_ack_err(ack)));
    chk({tag, " ack_sticky"}, 32'(bus.ack_err), 32'(exp_ack_err(ack)));
    chk({tag, " idle"}, 32'(bus.tx_idle), 32'd1);
  endtask

  initial begin
    int t0;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    #1;
    chk("rst oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    chk("rst idle", 32'(bus.tx_idle), 32'd1);
    chk("rst tick", 32'(bus.tx_done_tick), 32'd0);
    chk("rst ack", 32'(bus.ack_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the middle of the data phase: data bit 0 holds ps2d low.
    bus.wr_ps2 = 1'b1;
    bus.din    = 8'h00;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    repeat (RTS + HALF) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_c = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_c = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    chk("mid-data ps2d_oe", 32'(ps2d_oe), 32'd1);
    t0 = tick_cnt;
    #2 reset = 1'b0;
    #1 chk("async rst oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    dev_c = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("post rst idle", 32'(bus.tx_idle), 32'd1);
    chk("post rst no tick", 32'(tick_cnt - t0), 32'd0);

    send(8'hF4, 1'b1, 1'b0, 1'b0, "F4");
    send(8'hED, 1'b1, 1'b0, 1'b1, "ED busy");
    send(8'h3C, 1'b0, 1'b0, 1'b0, "3C noack");
    send(8'hA7, 1'b1, 1'b1, 1'b0, "A7 glitch");
    for (int r = 0; r < 4; r++) begin
      logic [7:0] rb;
      bit         rg;
      rb = 8'($urandom);
      rg = 1'($urandom_range(1));
      send(rb, 1'b1, rg, 1'b0, $sformatf("rand%0d_%02h", r, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
